obstacle_lane_buffer: RTL and testbench

- Ring buffer of obstacle IDs, one per 32-pixel map column, sitting directly upstream of the VGA renderer.
- The CPU-side register path pushes IDs in level order.
- Once per frame the block advances the horizontal scroll and retires columns that have scrolled off the left edge.
- During active video it translates the renderer's pixel column into the obstacle ID and intra-tile pixel offset under that pixel, with fixed 2-cycle latency.

---
 rtl/obstacle_lane_buffer_if.sv | 31 +++
 rtl/obstacle_lane_buffer.sv | 152 +++++++++++++++
 tb/tb_obstacle_lane_buffer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/obstacle_lane_buffer_if.sv
// rtl/obstacle_lane_buffer_if.sv - write, scroll and pixel-lookup signals of the obstacle lane buffer
interface obstacle_lane_buffer_if #(
    parameter int DEPTH     = 64,
    parameter int ID_W      = 8,
    parameter int TILE_LOG2 = 5
);
    logic                       clear;
    logic [ID_W-1:0]            wr_id;
    logic                       wr_valid;
    logic                       wr_ready;
    logic                       frame_start;
    logic [TILE_LOG2-1:0]       scroll_step;
    logic                       pix_req;
    logic [9:0]                 pix_x;
    logic [ID_W-1:0]            tile_id;
    logic [TILE_LOG2-1:0]       tile_px;
    logic                       tile_valid;
    logic [$clog2(DEPTH):0]     level;
    logic                       low_water;
    logic                       underrun;

    modport slave (
        input  clear, wr_id, wr_valid, frame_start, scroll_step, pix_req, pix_x,
        output wr_ready, tile_id, tile_px, tile_valid, level, low_water, underrun
    );

    modport master (
        output clear, wr_id, wr_valid, frame_start, scroll_step, pix_req, pix_x,
        input  wr_ready, tile_id, tile_px, tile_valid, level, low_water, underrun
    );
endinterface

// File: rtl/obstacle_lane_buffer.sv
// rtl/obstacle_lane_buffer.sv - obstacle ID ring buffer with per-frame scroll and 2-cycle pixel lookup
module obstacle_lane_buffer #(
    parameter int DEPTH     = 64,
    parameter int ID_W      = 8,
    parameter int TILE_LOG2 = 5,
    parameter int VISIBLE   = 21
) (
    input  logic                   clk,
    input  logic                   reset,
    obstacle_lane_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int X_W   = 11;

    logic [ID_W-1:0]      mem [DEPTH];

    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [TILE_LOG2-1:0] fine_x_q, fine_x_d;
    logic                 underrun_q, underrun_d;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_hit_q, s1_hit_d;
    logic [PTR_W-1:0]     s1_addr_q, s1_addr_d;
    logic [TILE_LOG2-1:0] s1_px_q, s1_px_d;

    logic [ID_W-1:0]      tile_id_q, tile_id_d;
    logic [TILE_LOG2-1:0] tile_px_q, tile_px_d;
    logic                 tile_valid_q, tile_valid_d;

    logic                 wr_ready_c;
    logic                 wr_fire;
    logic                 retire;
    logic                 carry;
    logic [TILE_LOG2:0]   scroll_sum;
    logic [X_W-1:0]       abs_x;
    logic [X_W-1:0]       col;

    assign wr_ready_c = (count_q < CNT_W'(DEPTH));
    assign wr_fire    = bus.wr_valid && wr_ready_c && !bus.clear;
    assign scroll_sum = {1'b0, fine_x_q} + {1'b0, bus.scroll_step};
    assign carry      = bus.frame_start && scroll_sum[TILE_LOG2];
    assign retire     = carry && (count_q != '0);

    // Lookup uses the pre-update pointers/count/scroll of the request cycle.
    assign abs_x = X_W'(bus.pix_x) + X_W'(fine_x_q);
    assign col   = abs_x >> TILE_LOG2;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fine_x_d     = fine_x_q;
        underrun_d   = underrun_q;
        s1_valid_d   = 1'b0;
        s1_hit_d     = s1_hit_q;
        s1_addr_d    = s1_addr_q;
        s1_px_d      = s1_px_q;
        tile_valid_d = 1'b0;
        tile_id_d    = tile_id_q;
        tile_px_d    = tile_px_q;

        if (bus.clear) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fine_x_d   = '0;
            underrun_d = 1'b0;
            tile_id_d  = '0;
            tile_px_d  = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (bus.frame_start) begin
                fine_x_d = scroll_sum[TILE_LOG2-1:0];
            end
            if (retire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (carry && (count_q == '0)) begin
                underrun_d = 1'b1;
            end
            // A write and a retire in the same cycle cancel out in the count.
            if (wr_fire && !retire) begin
                count_d = count_q + 1'b1;
            end else if (retire && !wr_fire) begin
                count_d = count_q - 1'b1;
            end

            s1_valid_d = bus.pix_req;
            if (bus.pix_req) begin
                s1_hit_d  = (col < X_W'(count_q));
                s1_addr_d = rd_ptr_q + PTR_W'(col);
                s1_px_d   = abs_x[TILE_LOG2-1:0];
            end

            tile_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                tile_id_d = s1_hit_q ? mem[s1_addr_q] : '0;
                tile_px_d = s1_px_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            fine_x_q     <= '0;
            underrun_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_hit_q     <= 1'b0;
            s1_addr_q    <= '0;
            s1_px_q      <= '0;
            tile_valid_q <= 1'b0;
            tile_id_q    <= '0;
            tile_px_q    <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fine_x_q     <= fine_x_d;
            underrun_q   <= underrun_d;
            s1_valid_q   <= s1_valid_d;
            s1_hit_q     <= s1_hit_d;
            s1_addr_q    <= s1_addr_d;
            s1_px_q      <= s1_px_d;
            tile_valid_q <= tile_valid_d;
            tile_id_q    <= tile_id_d;
            tile_px_q    <= tile_px_d;
        end
    end

    // Storage is deliberately not reset; hit gating keeps stale slots invisible.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= bus.wr_id;
        end
    end

    assign bus.wr_ready   = wr_ready_c;
    assign bus.level      = count_q;
    assign bus.low_water  = (count_q < CNT_W'(VISIBLE));
    assign bus.underrun   = underrun_q;
    assign bus.tile_id    = tile_id_q;
    assign bus.tile_px    = tile_px_q;
    assign bus.tile_valid = tile_valid_q;
endmodule

// File: tb/tb_obstacle_lane_buffer.sv
// tb/tb_obstacle_lane_buffer.sv - scoreboard bench for obstacle_lane_buffer
module tb_obstacle_lane_buffer;
    localparam int DEPTH   = 64;
    localparam int VISIBLE = 21;

    logic clk = 1'b0;
    logic rst = 1'b1;

    obstacle_lane_buffer_if #(.DEPTH(DEPTH), .ID_W(8), .TILE_LOG2(5)) bus ();

    obstacle_lane_buffer #(.DEPTH(DEPTH), .ID_W(8), .TILE_LOG2(5), .VISIBLE(VISIBLE)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        int id;
        int px;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   lane[$];
    int   fine = 0;
    bit   und  = 1'b0;
    int   cyc  = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        lane.delete();
        fine = 0;
        und  = 1'b0;
    endtask

    task automatic step(bit clr, bit wv, int wid, bit fs, int st, bit rq, int px);
        exp_t e;
        int   a, n, s;
        bit   acc;
        bus.clear       = clr;
        bus.wr_valid    = wv;
        bus.wr_id       = 8'(wid);
        bus.frame_start = fs;
        bus.scroll_step = 5'(st);
        bus.pix_req     = rq;
        bus.pix_x       = 10'(px);
        if (rq && !clr) begin
            a     = px + fine;
            e.id  = ((a / 32) < lane.size()) ? lane[a / 32] : 0;
            e.px  = a % 32;
            e.due = cyc + 2;
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            n   = lane.size();
            acc = wv && (n < DEPTH);
            if (fs) begin
                s    = fine + st;
                fine = s % 32;
                if (s >= 32) begin
                    if (n > 0) void'(lane.pop_front());
                    else und = 1'b1;
                end
            end
            if (acc) lane.push_back(wid);
        end
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(int id);
        step(0, 1, id, 0, 0, 0, 0);
    endtask

    task automatic look(int px);
        step(0, 0, 0, 0, 0, 1, px);
    endtask

    task automatic do_clear();
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: state checks every cycle, lookup results against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("level", int'(bus.level), lane.size());
            chk("low_water", int'(bus.low_water), int'(lane.size() < VISIBLE));
            chk("wr_ready", int'(bus.wr_ready), int'(lane.size() < DEPTH));
            chk("underrun", int'(bus.underrun), int'(und));
            if (bus.tile_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_tile_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("lookup_latency", cyc, e.due);
                    chk("tile_id", int'(bus.tile_id), e.id);
                    chk("tile_px", int'(bus.tile_px), e.px);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("missing_tile_valid", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.clear = 0; bus.wr_valid = 0; bus.wr_id = 0; bus.frame_start = 0;
        bus.scroll_step = 0; bus.pix_req = 0; bus.pix_x = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level", int'(bus.level), 0);
        chk("reset_wr_ready", int'(bus.wr_ready), 1);
        chk("reset_low_water", int'(bus.low_water), 1);
        chk("reset_tile_valid", int'(bus.tile_valid), 0);
        rst = 1'b0;

        // Fill to full, then an ignored extra push
        for (int i = 1; i <= 64; i++) push(i);
        chk("full_level", int'(bus.level), 64);
        chk("full_wr_ready", int'(bus.wr_ready), 0);
        chk("full_low_water", int'(bus.low_water), 0);
        push(65);
        chk("overfull_level", int'(bus.level), 64);
        look(639);
        idle(3);

        // Basic lookups with fine_x = 0
        do_clear();
        for (int i = 1; i <= 21; i++) push(i);
        look(0); look(31); look(32); look(639);
        idle(3);

        // Scroll 20 + 20 -> one retire, fine_x 8
        step(0, 0, 0, 1, 20, 0, 0);
        step(0, 0, 0, 1, 20, 0, 0);
        chk("scroll_level", int'(bus.level), 20);
        look(0);
        idle(3);

        // Underrun on empty buffer
        do_clear();
        step(0, 0, 0, 1, 31, 0, 0);
        step(0, 0, 0, 1, 31, 0, 0);
        chk("underrun_set", int'(bus.underrun), 1);
        chk("underrun_level", int'(bus.level), 0);
        look(100);
        idle(3);

        // Write coinciding with a retire
        do_clear();
        for (int i = 1; i <= 10; i++) push(100 + i);
        step(0, 0, 0, 1, 31, 0, 0);
        step(0, 1, 111, 1, 1, 0, 0);
        chk("wr_retire_level", int'(bus.level), 10);
        look(0); look(300);
        idle(3);
        do_clear();
        #0;
        chk("clear_level", int'(bus.level), 0);
        chk("clear_underrun", int'(bus.underrun), 0);
        chk("clear_low_water", int'(bus.low_water), 1);

        // Random traffic wrapping the pointers several times
        for (int i = 0; i < 1500; i++) begin
            step(0, ($urandom_range(0, 99) < 55), $urandom_range(1, 255),
                 ($urandom_range(0, 99) < 30), $urandom_range(0, 31),
                 ($urandom_range(0, 99) < 60), $urandom_range(0, 639));
        end
        idle(3);

        // Asynchronous reset mid-fill with a lookup in flight
        for (int i = 0; i < 30; i++) push(i + 1);
        step(0, 0, 0, 1, 31, 0, 0);
        step(0, 0, 0, 1, 31, 0, 0);
        look(40);
        rst = 1'b1;
        #1;
        exp_q.delete();
        model_reset();
        chk("async_level", int'(bus.level), 0);
        chk("async_wr_ready", int'(bus.wr_ready), 1);
        chk("async_low_water", int'(bus.low_water), 1);
        chk("async_underrun", int'(bus.underrun), 0);
        chk("async_tile_valid", int'(bus.tile_valid), 0);
        chk("async_tile_id", int'(bus.tile_id), 0);
        chk("async_tile_px", int'(bus.tile_px), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(7);
        look(0);
        idle(4);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
